// File: rtl/ika2151_noise.sv
// IKA2151 noise generator: a 5-bit rate counter, a pending flag and a 17-bit XNOR LFSR.
// Optional: define IKA2151_NOISE_LFSR_DEBUG_EN to expose the LFSR state on o_NOISE_LFSR.
module ika2151_noise (
  input  logic        i_EMUCLK,
  input  logic        i_MRST,
  input  logic        i_phi1_NCEN_n,
  input  logic        i_CYCLE_12,
  input  logic        i_CYCLE_15_31,
  input  logic        i_NE,
  input  logic [4:0]  i_NFRQ,
  output logic        o_NOISE,
  output logic        o_NOISE_UPDATE
`ifdef IKA2151_NOISE_LFSR_DEBUG_EN
  ,
  output logic [16:0] o_NOISE_LFSR
`endif
);

  // One right shift; the XNOR feedback keeps the all-zero reset state inside the sequence.
  function automatic logic [16:0] lfsr_step(input logic [16:0] cur);
    lfsr_step = {~(cur[0] ^ cur[3]), cur[16:1]};
  endfunction

  logic [4:0]  freq_cnt;
  logic [4:0]  freq_cnt_nxt;
  logic        pending;
  logic        pending_nxt;
  logic [16:0] lfsr;
  logic [16:0] lfsr_nxt;
  logic        noise_nxt;
  logic        update_nxt;
  logic        match;
  logic        consume;

  // Next-state logic for counter, pending flag, LFSR and outputs.
  always_comb begin
    match        = i_CYCLE_15_31 & (freq_cnt == ~i_NFRQ);
    consume      = i_CYCLE_12 & pending;
    freq_cnt_nxt = freq_cnt;
    pending_nxt  = pending;
    lfsr_nxt     = lfsr;
    noise_nxt    = o_NOISE;
    update_nxt   = 1'b0;

    if (i_CYCLE_15_31) begin
      if (match) begin
        freq_cnt_nxt = 5'd0;
      end else begin
        freq_cnt_nxt = freq_cnt + 5'd1;
      end
    end else begin
      freq_cnt_nxt = freq_cnt;
    end

    // A fresh match wins over a same-edge consume so that no event is lost.
    if (match) begin
      pending_nxt = 1'b1;
    end else if (consume) begin
      pending_nxt = 1'b0;
    end else begin
      pending_nxt = pending;
    end

    if (consume) begin
      lfsr_nxt   = lfsr_step(lfsr);
      noise_nxt  = i_NE & lfsr[0];
      update_nxt = 1'b1;
    end else begin
      lfsr_nxt   = lfsr;
      noise_nxt  = o_NOISE;
      update_nxt = 1'b0;
    end
  end

  // State registers; advance only on phi1-enabled edges.
  always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
    if (i_MRST) begin
      freq_cnt       <= 5'd0;
      pending        <= 1'b0;
      lfsr           <= 17'h00000;
      o_NOISE        <= 1'b0;
      o_NOISE_UPDATE <= 1'b0;
    end else if (!i_phi1_NCEN_n) begin
      freq_cnt       <= freq_cnt_nxt;
      pending        <= pending_nxt;
      lfsr           <= lfsr_nxt;
      o_NOISE        <= noise_nxt;
      o_NOISE_UPDATE <= update_nxt;
    end else begin
      freq_cnt       <= freq_cnt;
      pending        <= pending;
      lfsr           <= lfsr;
      o_NOISE        <= o_NOISE;
      o_NOISE_UPDATE <= o_NOISE_UPDATE;
    end
  end

`ifdef IKA2151_NOISE_LFSR_DEBUG_EN
  assign o_NOISE_LFSR = lfsr;
`endif

endmodule

// File: tb/tb_ika2151_noise.sv
// Directed bench for ika2151_noise: rates, LFSR sequence, enable gating, reset and strobe corner cases.
module tb_ika2151_noise;

  logic       clk = 1'b0;
  logic       rst;
  logic       ncen;
  logic       c12;
  logic       c1531;
  logic       ne;
  logic [4:0] nfrq;
  logic       noise;
  logic       upd;

  int          checks = 0;
  int          errors = 0;
  int          fpos   = 0;
  logic [16:0] m_lfsr = 17'h00000;

  ika2151_noise dut (
    .i_EMUCLK       (clk),
    .i_MRST         (rst),
    .i_phi1_NCEN_n  (ncen),
    .i_CYCLE_12     (c12),
    .i_CYCLE_15_31  (c1531),
    .i_NE           (ne),
    .i_NFRQ         (nfrq),
    .o_NOISE        (noise),
    .o_NOISE_UPDATE (upd)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic s12, input logic s1531);
    c12   = s12;
    c1531 = s1531;
    @(posedge clk);
    #1;
  endtask

  // One phi1 cycle of a correctly phased timing generator.
  task automatic gen_tick();
    tick(fpos == 12, (fpos == 15) || (fpos == 31));
    fpos = (fpos + 1) % 32;
  endtask

  task automatic wait_update(input int maxc, output int gap);
    gap = 0;
    do begin
      gen_tick();
      gap++;
    end while (upd !== 1'b1 && gap < maxc);
    if (upd !== 1'b1) check_val("upd_timeout", {31'd0, upd}, 32'd1);
  endtask

  task automatic model_shift(output logic exp_noise);
    exp_noise = ne & m_lfsr[0];
    m_lfsr    = {~(m_lfsr[0] ^ m_lfsr[3]), m_lfsr[16:1]};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    c12    = 1'b0;
    c1531  = 1'b0;
    fpos   = 0;
    m_lfsr = 17'h00000;
  endtask

  initial begin
    int   gap;
    logic en;
    int   period;
    logic [16:0] p;

    rst = 1'b1; ncen = 1'b0; c12 = 1'b0; c1531 = 1'b0; ne = 1'b1; nfrq = 5'd31;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_noise", {31'd0, noise}, 32'd0);
    check_val("rst_upd", {31'd0, upd}, 32'd0);
    check_val("rst_lfsr", {15'd0, dut.lfsr}, 32'h0);
    check_val("rst_cnt", {27'd0, dut.freq_cnt}, 32'd0);
    rst = 1'b0;

    // NFRQ=31: every strobe matches, pairs collapse to one update per frame.
    wait_update(100, gap);
    model_shift(en);
    check_val("n31_gap1", 32'(gap), 32'd45);
    check_val("n31_lfsr1", {15'd0, dut.lfsr}, 32'h10000);
    wait_update(100, gap);
    model_shift(en);
    check_val("n31_gap2", 32'(gap), 32'd32);
    check_val("n31_lfsr2", {15'd0, dut.lfsr}, 32'h18000);
    wait_update(100, gap);
    model_shift(en);
    check_val("n31_gap3", 32'(gap), 32'd32);
    check_val("n31_lfsr3", {15'd0, dut.lfsr}, 32'h1C000);
    for (int n = 4; n <= 18; n++) begin
      wait_update(100, gap);
      model_shift(en);
      check_val($sformatf("seq_gap%0d", n), 32'(gap), 32'd32);
      check_val($sformatf("seq_noise%0d", n), {31'd0, noise}, (n == 18) ? 32'd1 : 32'd0);
      check_val($sformatf("seq_lfsr%0d", n), {15'd0, dut.lfsr}, {15'd0, m_lfsr});
    end

    // Asynchronous reset with both outputs high.
    check_val("pre_rst_noise", {31'd0, noise}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_noise", {31'd0, noise}, 32'd0);
    check_val("async_rst_upd", {31'd0, upd}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; c12 = 1'b0; c1531 = 1'b0;
    check_val("post_rst_lfsr", {15'd0, dut.lfsr}, 32'h0);
    check_val("post_rst_cnt", {27'd0, dut.freq_cnt}, 32'd0);
    check_val("post_rst_pend", {31'd0, dut.pending}, 32'd0);

    // NFRQ=0: one match every 32 strobes, i.e. every 512 phi1 cycles.
    fpos = 0; m_lfsr = 17'h00000; nfrq = 5'd0;
    wait_update(600, gap);
    check_val("n0_gap1", 32'(gap), 32'd525);
    check_val("n0_lfsr1", {15'd0, dut.lfsr}, 32'h10000);
    wait_update(600, gap);
    check_val("n0_gap2", 32'(gap), 32'd512);
    check_val("n0_lfsr2", {15'd0, dut.lfsr}, 32'h18000);

    // Directed strobes: match at count 31, then NFRQ change mid-count.
    do_reset();
    nfrq = 5'd0;
    repeat (31) tick(1'b0, 1'b1);
    check_val("cnt31", {27'd0, dut.freq_cnt}, 32'd31);
    check_val("cnt31_pend", {31'd0, dut.pending}, 32'd0);
    tick(1'b0, 1'b1);
    check_val("match31_cnt", {27'd0, dut.freq_cnt}, 32'd0);
    check_val("match31_pend", {31'd0, dut.pending}, 32'd1);
    tick(1'b1, 1'b0);
    model_shift(en);
    check_val("consume_upd", {31'd0, upd}, 32'd1);
    check_val("consume_pend", {31'd0, dut.pending}, 32'd0);
    repeat (5) tick(1'b0, 1'b1);
    check_val("cnt5", {27'd0, dut.freq_cnt}, 32'd5);
    nfrq = 5'd30;
    repeat (28) tick(1'b0, 1'b1);
    check_val("wrap_cnt1", {27'd0, dut.freq_cnt}, 32'd1);
    check_val("wrap_pend0", {31'd0, dut.pending}, 32'd0);
    tick(1'b0, 1'b1);
    check_val("wrap_match_cnt", {27'd0, dut.freq_cnt}, 32'd0);
    check_val("wrap_match_pend", {31'd0, dut.pending}, 32'd1);

    // Both strobes on one edge: shift with old pending, new match keeps it set.
    nfrq = 5'd31;
    tick(1'b1, 1'b1);
    model_shift(en);
    check_val("both_upd", {31'd0, upd}, 32'd1);
    check_val("both_pend", {31'd0, dut.pending}, 32'd1);
    check_val("both_lfsr", {15'd0, dut.lfsr}, {15'd0, m_lfsr});
    tick(1'b0, 1'b0);
    check_val("idle_upd", {31'd0, upd}, 32'd0);

    // Disabled phi1 enable: nothing moves.
    ncen = 1'b1;
    tick(1'b1, 1'b1);
    check_val("ncen_upd", {31'd0, upd}, 32'd0);
    check_val("ncen_lfsr", {15'd0, dut.lfsr}, {15'd0, m_lfsr});
    check_val("ncen_pend", {31'd0, dut.pending}, 32'd1);
    ncen = 1'b0;

    // Noise gating: NE=0 forces 0 but updates continue; re-enable follows the model.
    ne = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b1);
      model_shift(en);
      check_val($sformatf("ne0_upd%0d", i), {31'd0, upd}, 32'd1);
      check_val($sformatf("ne0_noise%0d", i), {31'd0, noise}, 32'd0);
    end
    check_val("ne0_lfsr", {15'd0, dut.lfsr}, {15'd0, m_lfsr});
    ne = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b1);
      model_shift(en);
      check_val($sformatf("ne1_noise%0d", i), {31'd0, noise}, {31'd0, en});
    end

    // Long run from reset, one shift per edge.
    do_reset();
    nfrq = 5'd31;
    repeat (4000) tick(1'b1, 1'b1);
    for (int i = 0; i < 3999; i++) model_shift(en);
    check_val("long_lfsr", {15'd0, dut.lfsr}, {15'd0, m_lfsr});

    // Reference sequence period from the reset state.
    p = 17'h00000;
    period = 0;
    do begin
      p = {~(p[0] ^ p[3]), p[16:1]};
      period++;
    end while (p != 17'h00000 && period < 140000);
    check_val("lfsr_period", 32'(period), 32'd131071);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ika2151_noise.md
IKA2151_NOISE -- requirements
Module: IKA2151_noise

Interface
REQ-001 The block SHALL have the port i_EMUCLK, input, 1 bit: emulator master clock; the only clock.
REQ-002 The block SHALL have the port i_MRST, input, 1 bit: reset, asynchronous, active-high.
REQ-003 The block SHALL have the port i_phi1_NCEN_n, input, 1 bit: phi1 negative-edge clock enable, active-low; all state advances only on i_EMUCLK rising edges where it is 0.
REQ-004 The block SHALL have the port i_CYCLE_12, input, 1 bit: timing strobe, one phi1 cycle per 32-cycle frame.
REQ-005 The block SHALL have the port i_CYCLE_15_31, input, 1 bit: timing strobe, two phi1 cycles per frame, 16 apart.
REQ-006 The block SHALL have the port i_NE, input, 1 bit: noise enable register bit.
REQ-007 The block SHALL have the port i_NFRQ, input, 5 bits: noise frequency register.
REQ-008 The block SHALL have the port o_NOISE, output, 1 bit: registered noise bit, gated by i_NE.
REQ-009 The block SHALL have the port o_NOISE_UPDATE, output, 1 bit: one-phi1-cycle pulse marking an LFSR shift.

Function
REQ-010 The block SHALL define an enabled edge as an i_EMUCLK rising edge with i_phi1_NCEN_n=0; all registers SHALL hold their value on every other edge.
REQ-011 The block SHALL contain a 5-bit frequency counter that is evaluated on each enabled edge with i_CYCLE_15_31=1.
REQ-012 On such an edge, the frequency counter SHALL load 0 and set the pending flag if counter == ~i_NFRQ, and SHALL otherwise increment modulo 32 (31 wraps to 0).
REQ-013 When i_NFRQ changes so that the counter already exceeds the new target, the counter SHALL continue counting, wrap through 0 and match on a later pass; no reload SHALL occur.
REQ-014 The block SHALL contain a 1-bit pending flag; a second match before it is consumed SHALL collapse into the single pending event.
REQ-015 On each enabled edge with i_CYCLE_12=1 and pending=1, the 17-bit LFSR SHALL shift right with new bit16 = lfsr[0] XNOR lfsr[3], and pending SHALL clear.
REQ-016 On the REQ-015 shift edge, o_NOISE SHALL load i_NE & lfsr[0] (the pre-shift value) and o_NOISE_UPDATE SHALL load 1.
REQ-017 On every other enabled edge, o_NOISE_UPDATE SHALL load 0 and o_NOISE SHALL keep its value.
REQ-018 When i_NE=0, o_NOISE SHALL be 0 from the next shift edge onward; the counter and LFSR SHALL run regardless of i_NE.
REQ-019 A match and a consume SHALL NOT coincide with correctly phased strobes; if both strobes are high on the same enabled edge, the shift SHALL use the old pending value and the new match SHALL leave pending=1.
REQ-020 The LFSR period SHALL be 131071 shifts; the all-ones state is a lockup and SHALL be unreachable from the reset state.

Reset
REQ-021 i_MRST=1 SHALL immediately clear, independent of clock and enable, the frequency counter, pending flag, LFSR (17'h00000), o_NOISE and o_NOISE_UPDATE.
REQ-022 Reset asserted mid-count or with pending=1 SHALL discard the pending event; counting SHALL restart from 0 on the first i_CYCLE_15_31 edge after release.

Configuration
REQ-023 With macro IKA2151_NOISE_LFSR_DEBUG_EN defined, the block SHALL add the output port o_NOISE_LFSR[16:0], driven directly from the LFSR register.
REQ-024 Without IKA2151_NOISE_LFSR_DEBUG_EN, the port SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-025 The bench SHALL check reset: assert i_MRST mid-run -> all outputs 0 immediately, LFSR=0 and counter=0 after release.
REQ-026 The bench SHALL check NFRQ=31, NE=1 with the timing generator running: o_NOISE_UPDATE pulses every 32 phi1 cycles (pending collapse) and the LFSR goes 0x00000 -> 0x10000 -> 0x18000 -> 0x1C000.
REQ-027 The bench SHALL check NFRQ=0: updates every 512 phi1 cycles, with a counter match at count 31.
REQ-028 The bench SHALL check the sequence from reset: o_NOISE=0 for the first 17 updates and 1 on update 18; after 131071 shifts the LFSR returns to 0x00000.
REQ-029 The bench SHALL check i_NE=0: o_NOISE stays 0 while o_NOISE_UPDATE keeps pulsing; on re-enable, o_NOISE matches a reference model at the next shift.
REQ-030 The bench SHALL check i_NFRQ changed from 0 to 30 with the counter at 5: the counter wraps and matches at 1 after 28 strobes.
